// File: rtl/stuff_data_extract_if.sv
// rtl/stuff_data_extract_if.sv - slot-stream / compacted-data bundle for stuff_data_extract
//
// Purpose: groups the framed slot input, the compacted data output, the
// frame count report and the error pulses of stuff_data_extract.
//
// Signals:
//   pm, cm_exp            frame parameters, sampled on the sof cycle
//   sof                   one-cycle start-of-frame pulse (carries no slot)
//   valid_in, ds, data_in slot strobe, slot type (1 = data), payload
//   data_out, valid_out   forwarded data word and its strobe
//   cm_out, cm_valid      recovered data count of the last completed frame
//   err_sof_early         sof before the open frame was complete
//   err_sof_late          slot while no frame was open
//   err_cm                recovered count differs from cm_exp
//
// Modports: master drives the slot stream (source side), slave is the
// extractor.

interface stuff_data_extract_if #(
  parameter int MPT_W  = 8,
  parameter int DATA_W = 8
);
  logic [MPT_W-1:0]  pm;
  logic [MPT_W-1:0]  cm_exp;
  logic              sof;
  logic              valid_in;
  logic              ds;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [MPT_W-1:0]  cm_out;
  logic              cm_valid;
  logic              err_sof_early;
  logic              err_sof_late;
  logic              err_cm;

  modport master (
    output pm, cm_exp, sof, valid_in, ds, data_in,
    input  data_out, valid_out, cm_out, cm_valid,
    input  err_sof_early, err_sof_late, err_cm
  );

  modport slave (
    input  pm, cm_exp, sof, valid_in, ds, data_in,
    output data_out, valid_out, cm_out, cm_valid,
    output err_sof_early, err_sof_late, err_cm
  );
endinterface

// File: rtl/stuff_data_extract.sv
// rtl/stuff_data_extract.sv - drop stuff slots from a framed slot stream and report data count
//
// Purpose: consumes a framed slot stream tagged with ds (1 = data slot,
// 0 = stuff slot), forwards data-slot payloads as a compacted stream, and at
// the end of each frame reports the recovered data count. Flags sof arriving
// inside an unfinished frame and slots arriving outside any frame.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   sd_if  stuff_data_extract_if.slave (slot input, data output, count, errors)
//
// Build option: define SOD_CM_CHECK_EN to latch cm_exp on sof and pulse
// err_cm with cm_valid when the recovered count differs. Without it cm_exp
// is ignored and err_cm is tied low.
//
// All outputs are registered; data, count and error pulses appear one cycle
// after the input that caused them.

module stuff_data_extract #(
  parameter int MPT_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stuff_data_extract_if.slave   sd_if
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  state_e            state_q;
  logic [MPT_W-1:0]  pm_l_q;
  logic [MPT_W-1:0]  slot_cnt_q;
  logic [MPT_W-1:0]  data_cnt_q;
  logic [MPT_W-1:0]  data_cnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic              valid_out_q;
  logic [MPT_W-1:0]  cm_out_q;
  logic              cm_valid_q;
  logic              err_sof_early_q;
  logic              err_sof_late_q;

`ifdef SOD_CM_CHECK_EN
  logic [MPT_W-1:0]  cm_exp_l_q;
  logic              err_cm_q;
`endif

  // Count including the slot on the input this cycle; used both to advance
  // the counter and to report the final count on the frame's last slot.
  assign data_cnt_d = data_cnt_q + MPT_W'(sd_if.ds);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      pm_l_q          <= '0;
      slot_cnt_q      <= '0;
      data_cnt_q      <= '0;
      data_out_q      <= '0;
      valid_out_q     <= 1'b0;
      cm_out_q        <= '0;
      cm_valid_q      <= 1'b0;
      err_sof_early_q <= 1'b0;
      err_sof_late_q  <= 1'b0;
`ifdef SOD_CM_CHECK_EN
      cm_exp_l_q      <= '0;
      err_cm_q        <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      valid_out_q     <= 1'b0;
      cm_valid_q      <= 1'b0;
      err_sof_early_q <= 1'b0;
      err_sof_late_q  <= 1'b0;
`ifdef SOD_CM_CHECK_EN
      err_cm_q        <= 1'b0;
`endif

      case (state_q)
        ST_IDLE: begin
          if (sd_if.sof) begin
            // A slot coincident with sof is ignored; pm=0 opens no frame.
            if (sd_if.pm != '0) begin
              pm_l_q     <= sd_if.pm;
              slot_cnt_q <= MPT_W'(1);
              data_cnt_q <= '0;
`ifdef SOD_CM_CHECK_EN
              cm_exp_l_q <= sd_if.cm_exp;
`endif
              state_q    <= ST_FRAME;
            end
          end else if (sd_if.valid_in) begin
            err_sof_late_q <= 1'b1;
          end
        end

        ST_FRAME: begin
          if (sd_if.sof) begin
            // Abort the open frame: no count report, slot in this cycle lost.
            err_sof_early_q <= 1'b1;
            if (sd_if.pm != '0) begin
              pm_l_q     <= sd_if.pm;
              slot_cnt_q <= MPT_W'(1);
              data_cnt_q <= '0;
`ifdef SOD_CM_CHECK_EN
              cm_exp_l_q <= sd_if.cm_exp;
`endif
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (sd_if.valid_in) begin
            if (sd_if.ds) begin
              data_out_q  <= sd_if.data_in;
              valid_out_q <= 1'b1;
            end
            data_cnt_q <= data_cnt_d;
            if (slot_cnt_q == pm_l_q) begin
              cm_out_q   <= data_cnt_d;
              cm_valid_q <= 1'b1;
`ifdef SOD_CM_CHECK_EN
              err_cm_q   <= (data_cnt_d != cm_exp_l_q);
`endif
              state_q    <= ST_IDLE;
            end else begin
              slot_cnt_q <= slot_cnt_q + MPT_W'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sd_if.data_out      = data_out_q;
  assign sd_if.valid_out     = valid_out_q;
  assign sd_if.cm_out        = cm_out_q;
  assign sd_if.cm_valid      = cm_valid_q;
  assign sd_if.err_sof_early = err_sof_early_q;
  assign sd_if.err_sof_late  = err_sof_late_q;
`ifdef SOD_CM_CHECK_EN
  assign sd_if.err_cm        = err_cm_q;
`else
  assign sd_if.err_cm        = 1'b0;
`endif

endmodule

// File: doc/stuff_data_extract.md
# stuff_data_extract

Receive-side counterpart of the stuff-or-data slot generator. Consumes a framed slot stream tagged with `ds` (1 = data slot, 0 = stuff slot) and forwards only the data-slot words as a compacted stream. At the end of each frame it reports the recovered data count `cm`. It also flags framing errors: `sof` arriving too early, or slots arriving outside a frame.

## Interface
- `MPT_W`, 8, width of the slot-count fields (`pm`, `cm`).
- `DATA_W`, 8, width of the slot payload word.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pm`  in  MPT_W  slots per frame; sampled only on the `sof` cycle.
- `cm_exp`  in  MPT_W  expected data count; sampled on the `sof` cycle. Used only when `SOD_CM_CHECK_EN` is defined.
- `sof`  in  1  one-cycle start-of-frame pulse. It precedes the first slot and carries no slot.
- `valid_in`  in  1  the current cycle carries one slot.
- `ds`  in  1  slot type, qualified by `valid_in`.
- `data_in`  in  DATA_W  slot payload.
- `data_out`  out  DATA_W  forwarded data word.
- `valid_out`  out  1  `data_out` is valid this cycle.
- `cm_out`  out  MPT_W  recovered data-slot count of the last completed frame.
- `cm_valid`  out  1  one-cycle pulse indicating `cm_out` has been updated.
- `err_sof_early`  out  1  one-cycle pulse: `sof` arrived before `pm` slots were received.
- `err_sof_late`  out  1  one-cycle pulse: a slot arrived while no frame was open.
- `err_cm`  out  1  one-cycle pulse: recovered count differs from `cm_exp` (check build only).

## Operation
- States: IDLE and FRAME. Internal registers:
  - `pm_l`, `cm_exp_l`: latched frame parameters.
  - `slot_cnt`: MPT_W bits, the index of the next slot, starting at 1.
  - `data_cnt`: MPT_W bits.
- IDLE:
  - `sof`=1 with `pm`≠0: latch `pm`/`cm_exp`, set `slot_cnt`=1 and `data_cnt`=0, go to FRAME.
  - `sof`=1 with `pm`=0: ignore it and stay in IDLE. No error is raised.
  - `valid_in`=1 without `sof`: drop the slot, pulse `err_sof_late`, emit no data.
  - `sof`=1 together with `valid_in`=1: the `sof` is handled as above. The slot is ignored and no error is raised.
- FRAME, `valid_in`=1 and `sof`=0:
  - If `ds`=1: `data_out`←`data_in`, `valid_out`=1, `data_cnt`++.
  - If `slot_cnt`==`pm_l` (last slot): `cm_out`←final `data_cnt`, including this slot. Pulse `cm_valid` and go to IDLE.
  - Otherwise: `slot_cnt`++.
- FRAME, `valid_in`=0: hold all state. `valid_out`=0.
- FRAME, `sof`=1 (with or without `valid_in`):
  - Pulse `err_sof_early` and abort the current frame. No `cm_valid` is produced for it, and the slot in that cycle is dropped.
  - Restart FRAME with the newly sampled `pm`/`cm_exp`. If the new `pm`=0, go to IDLE instead.
- Arithmetic:
  - `slot_cnt` and `data_cnt` never exceed `pm_l` ≤ 2^MPT_W−1, so no wrap is possible.
  - The comparison `slot_cnt`==`pm_l` is an exact MPT_W-bit equality.
- `cm_out` holds its value between frames. It is unchanged by aborted frames.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - State = IDLE.
  - `data_out`=0, `valid_out`=0.
  - `cm_out`=0, `cm_valid`=0.
  - `err_sof_early`=0, `err_sof_late`=0, `err_cm`=0.
  - All counters and latched parameters = 0.
- Deasserting reset during a frame discards that frame. The first `sof` after reset starts a clean frame.
- Latency, measured from the input edge to the registered output:
  - Data word: 1 cycle.
  - `cm_valid`, `cm_out`, `err_cm`: 1 cycle after the last slot, on the same edge as that slot's `valid_out`.
  - Error flags: 1 cycle after the offending input.
- Throughput: one slot per cycle, with no backpressure. A new `sof` may arrive on the cycle immediately after the last slot.
- All pulse outputs are high for exactly one cycle per event.

## Configuration
- `SOD_CM_CHECK_EN` defined:
  - On each completed frame, compare the recovered count against `cm_exp_l`.
  - If they differ, pulse `err_cm` together with `cm_valid`.
- `SOD_CM_CHECK_EN` undefined:
  - `cm_exp` is ignored and no comparator or latch is built.
  - `err_cm` is tied to 0.
- The port list is identical in both builds.

## Test plan
- **Nominal frame:** `pm`=8, `cm_exp`=6, `sof`, then 8 back-to-back slots with `ds`=1,1,0,1,1,0,1,1 and `data_in`=0x10..0x17. Required response:
  - `data_out` = 0x10, 0x11, 0x13, 0x14, 0x16, 0x17.
  - `cm_out`=6 with `cm_valid` on the last word.
  - `err_cm`=0.
- **Gapped input:** the same frame with `valid_in` deasserted for 3 cycles after slot 4. Required response: identical output words and `cm_out`=6, with no error flags.
- **Early sof:** `pm`=5, 3 slots, then `sof` with `pm`=2 and 2 slots with `ds`=1. Required response:
  - `err_sof_early` pulses once.
  - Exactly one `cm_valid`, with `cm_out`=2.
- **Slot outside frame:** `valid_in`=1 with `ds`=1 in IDLE. Required response: `err_sof_late`=1 for one cycle, `valid_out`=0, `cm_out` unchanged.
- **Count check (`SOD_CM_CHECK_EN` defined):** `pm`=4, `cm_exp`=3, all `ds`=1. Required response: `cm_out`=4 and `err_cm`=1. Without the macro, `err_cm` stays 0.
- **Reset mid-frame and pm=0:** assert `rst_n`=0 after slot 2 of a `pm`=6 frame, then `sof` with `pm`=0. Required response:
  - All outputs read 0 during reset.
  - The block stays in IDLE, and a following `valid_in` raises `err_sof_late`.
